// File: rtl/demux_eight_seq_if.sv
// Bus bundle for the 1-to-8 serial demultiplexer.
// Handshake rule (both directions): a transfer happens on a rising edge where
// valid && ready are both high; valid must not depend on ready, and the
// sender holds its data stable while valid is high and ready is low.
interface demux_eight_seq_if;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       mode;
  logic [2:0] s;
  logic [7:0] result;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] ptr;
  logic       overflow;
  logic       state_dbg;

  modport master (
    output din, din_valid, mode, s, out_ready,
    input  din_ready, result, out_valid, ptr, overflow, state_dbg
  );

  modport slave (
    input  din, din_valid, mode, s, out_ready,
    output din_ready, result, out_valid, ptr, overflow, state_dbg
  );
endinterface

// File: rtl/demux_eight_seq.sv
// Serial-to-parallel demultiplexer: addressed mode writes one lane of the
// result word per accepted bit, auto mode assembles whole words in a shadow
// register and presents them with a FILL/FULL handshake FSM.
module demux_eight_seq #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  demux_eight_seq_if.slave  bus
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] result_q, result_d;
  logic       out_valid_q, out_valid_d;
  logic       overflow_q, overflow_d;
  logic       mode_prev_q, mode_prev_d;

  logic       din_ready;
  logic       mode_chg;
  state_t     eff_state;
  logic [2:0] eff_ptr;
  logic [7:0] eff_shadow;
  logic [2:0] lane;
  logic [7:0] shadow_w;
  logic       accept;
  logic       take;
  logic       last_bit;

  // A mode change restarts word assembly in the same cycle, so the bit
  // offered then is handled as if the FSM were already freshly in FILL.
  assign mode_chg   = (bus.mode != mode_prev_q);
  assign eff_state  = mode_chg ? ST_FILL : state_q;
  assign eff_ptr    = mode_chg ? 3'd0 : ptr_q;
  assign eff_shadow = mode_chg ? 8'h00 : shadow_q;
  assign lane       = LSB_FIRST ? eff_ptr : (3'd7 - eff_ptr);
  assign accept     = bus.din_valid && din_ready;
  assign take       = out_valid_q && bus.out_ready;
  assign last_bit   = (eff_ptr == 3'd7);

  // Shadow word with the current bit merged into its auto-mode lane.
  always_comb begin
    shadow_w       = eff_shadow;
    shadow_w[lane] = bus.din;
  end

  // State register plus all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      ptr_q       <= 3'd0;
      shadow_q    <= 8'h00;
      result_q    <= 8'h00;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      mode_prev_q <= bus.mode;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      shadow_q    <= shadow_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  // Next-state logic of the auto-mode FILL/FULL FSM.
  always_comb begin
    state_d = state_q;
    if (!bus.mode) begin
      state_d = ST_FILL;
    end else begin
      case (eff_state)
        ST_FILL: state_d = (accept && last_bit) ? ST_FULL : ST_FILL;
        ST_FULL: begin
          if (accept && last_bit) state_d = ST_FULL;
          else if (take)          state_d = ST_FILL;
          else                    state_d = ST_FULL;
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  // Input-side ready: only stalls when a finished word would complete on top
  // of a word the consumer is not taking this cycle.
  always_comb begin
    din_ready = 1'b1;
    if (bus.mode && (eff_state == ST_FULL) && last_bit && !bus.out_ready) begin
      din_ready = 1'b0;
    end
  end

  // Datapath next values: lane writes, pointer, word hand-off, overflow.
  always_comb begin
    ptr_d       = eff_ptr;
    shadow_d    = eff_shadow;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    mode_prev_d = bus.mode;
    if (take) begin
      out_valid_d = 1'b0;
    end
    if (!bus.mode) begin
      if (accept) begin
        result_d[bus.s] = bus.din;
        out_valid_d     = 1'b1;
        if (out_valid_q && !bus.out_ready) begin
          overflow_d = 1'b1;
        end
      end
    end else if (accept) begin
      ptr_d    = eff_ptr + 3'd1;
      shadow_d = shadow_w;
      if (last_bit) begin
        result_d    = shadow_w;
        out_valid_d = 1'b1;
        shadow_d    = 8'h00;
      end
    end
  end

  assign bus.din_ready = din_ready;
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ptr       = ptr_q;
  assign bus.overflow  = overflow_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_demux_eight_seq.sv
// Directed bench for demux_eight_seq: one LSB-first and one MSB-first
// instance share the same stimulus.
module tb_demux_eight_seq;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       mode;
  logic [2:0] s;
  logic       out_ready;

  int checks;
  int errors;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  demux_eight_seq_if ifa ();
  demux_eight_seq_if ifb ();

  assign ifa.din = din;  assign ifa.din_valid = din_valid; assign ifa.mode = mode;
  assign ifa.s   = s;    assign ifa.out_ready = out_ready;
  assign ifb.din = din;  assign ifb.din_valid = din_valid; assign ifb.mode = mode;
  assign ifb.s   = s;    assign ifb.out_ready = out_ready;

  demux_eight_seq #(.LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .rst(rst), .bus(ifa));
  demux_eight_seq #(.LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst(rst), .bus(ifb));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      din       = w[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; out_ready = 1'b0; din_valid = 1'b0; din = 1'b0; s = 3'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (ifa.result !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", ifa.result); end
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ifa.out_valid); end
    checks++; if (ifa.ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", ifa.ptr); end
    checks++; if (ifa.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", ifa.overflow); end
    checks++; if (ifa.din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %b exp 1", ifa.din_ready); end
  endtask

  task automatic test_auto_order();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = exp_w[i]; din_valid = 1'b1;
      tick();
      if (i == 6) begin
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL auto_early_valid got %b exp 0", ifa.out_valid); end
      end
    end
    din_valid = 1'b0;
    checks++; if (ifa.result !== 8'h4D) begin errors++; $display("FAIL auto_lsb_result got %h exp 4d", ifa.result); end
    checks++; if (ifb.result !== 8'hB2) begin errors++; $display("FAIL auto_msb_result got %h exp b2", ifb.result); end
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL auto_valid got %b exp 1", ifa.out_valid); end
    checks++; if (ifa.ptr !== 3'd0) begin errors++; $display("FAIL auto_ptr_wrap got %0d exp 0", ifa.ptr); end
    tick();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL auto_valid_one_cycle got %b exp 0", ifa.out_valid); end
    checks++; if (ifa.state_dbg !== 1'b0) begin errors++; $display("FAIL auto_state_fill got %b exp 0", ifa.state_dbg); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    logic [7:0]  got;
    bits = 16'h3CA5;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      din = bits[i]; din_valid = 1'b1;
      #1;
      checks++; if (ifa.din_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready bit %0d got %b exp 1", i, ifa.din_ready); end
      tick();
      if (i == 7) begin
        checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_after_8 got %b exp 1", ifa.out_valid); end
      end
    end
    din = bits[15];
    #1;
    checks++; if (ifa.ptr !== 3'd7) begin errors++; $display("FAIL b2b_ptr7 got %0d exp 7", ifa.ptr); end
    checks++; if (ifa.din_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", ifa.din_ready); end
    tick();
    checks++; if (ifa.ptr !== 3'd7) begin errors++; $display("FAIL b2b_stall_hold got %0d exp 7", ifa.ptr); end
    got = exp_q.pop_front();
    checks++; if (ifa.result !== got) begin errors++; $display("FAIL b2b_word1 got %h exp %h", ifa.result, got); end
    out_ready = 1'b1;
    #1;
    checks++; if (ifa.din_ready !== 1'b1) begin errors++; $display("FAIL b2b_release got %b exp 1", ifa.din_ready); end
    tick();
    din_valid = 1'b0;
    got = exp_q.pop_front();
    checks++; if (ifa.result !== got) begin errors++; $display("FAIL b2b_word2 got %h exp %h", ifa.result, got); end
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_word2_valid got %b exp 1", ifa.out_valid); end
    checks++; if (ifa.ptr !== 3'd0) begin errors++; $display("FAIL b2b_ptr0 got %0d exp 0", ifa.ptr); end
    tick();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", ifa.out_valid); end
    checks++; if (ifa.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b exp 0", ifa.overflow); end
  endtask

  task automatic test_reset_midword();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 1'b1; din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    checks++; if (ifa.ptr !== 3'd5) begin errors++; $display("FAIL mid_ptr got %0d exp 5", ifa.ptr); end
    pulse_reset();
    #1;
    checks++; if (ifa.result !== 8'h00) begin errors++; $display("FAIL mid_rst_result got %h exp 00", ifa.result); end
    checks++; if (ifa.ptr !== 3'd0) begin errors++; $display("FAIL mid_rst_ptr got %0d exp 0", ifa.ptr); end
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", ifa.out_valid); end
    checks++; if (ifa.din_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", ifa.din_ready); end
    send_word(8'h96);
    checks++; if (ifa.result !== 8'h96) begin errors++; $display("FAIL mid_clean_word got %h exp 96", ifa.result); end
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL mid_clean_valid got %b exp 1", ifa.out_valid); end
    tick();
  endtask

  task automatic test_mode_switch();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 1'b1; din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    checks++; if (ifa.ptr !== 3'd3) begin errors++; $display("FAIL sw_ptr3 got %0d exp 3", ifa.ptr); end
    mode = 1'b0;
    tick();
    checks++; if (ifa.ptr !== 3'd0) begin errors++; $display("FAIL sw_ptr_clear got %0d exp 0", ifa.ptr); end
    checks++; if (ifa.result !== 8'h96) begin errors++; $display("FAIL sw_result_hold got %h exp 96", ifa.result); end
    mode = 1'b1;
    tick();
    checks++; if (ifa.ptr !== 3'd0) begin errors++; $display("FAIL sw_ptr_back got %0d exp 0", ifa.ptr); end
    send_word(8'h5A);
    checks++; if (ifa.result !== 8'h5A) begin errors++; $display("FAIL sw_word got %h exp 5a", ifa.result); end
    tick();
  endtask

  task automatic test_addressed();
    mode = 1'b0; out_ready = 1'b0; din_valid = 1'b0;
    pulse_reset();
    s = 3'd5; din = 1'b1; din_valid = 1'b1;
    tick();
    checks++; if (ifa.result !== 8'h20) begin errors++; $display("FAIL addr_first got %h exp 20", ifa.result); end
    checks++; if (ifa.overflow !== 1'b0) begin errors++; $display("FAIL addr_no_ovf got %b exp 0", ifa.overflow); end
    s = 3'd0; din = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++; if (ifa.result !== 8'h21) begin errors++; $display("FAIL addr_result got %h exp 21", ifa.result); end
    checks++; if (ifb.result !== 8'h21) begin errors++; $display("FAIL addr_result_msb got %h exp 21", ifb.result); end
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL addr_valid got %b exp 1", ifa.out_valid); end
    checks++; if (ifa.overflow !== 1'b1) begin errors++; $display("FAIL addr_ovf got %b exp 1", ifa.overflow); end
    out_ready = 1'b1;
    tick();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL addr_taken got %b exp 0", ifa.out_valid); end
    checks++; if (ifa.overflow !== 1'b1) begin errors++; $display("FAIL addr_ovf_sticky got %b exp 1", ifa.overflow); end
    mode = 1'b1;
    tick();
    checks++; if (ifa.overflow !== 1'b1) begin errors++; $display("FAIL addr_ovf_mode got %b exp 1", ifa.overflow); end
    pulse_reset();
    #1;
    checks++; if (ifa.overflow !== 1'b0) begin errors++; $display("FAIL addr_ovf_rst got %b exp 0", ifa.overflow); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_w  = 8'h4D;
    test_reset();
    test_auto_order();
    test_back_to_back();
    test_reset_midword();
    test_mode_switch();
    test_addressed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_eight_seq.md
DEMUX_EIGHT_SEQ -- requirements
Module: demux_eight_seq

Interface
REQ-001 Parameter: LSB_FIRST, default 1, auto-mode fill order (1: bit 0 first; 0: bit 7 first).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 din  input  1  serial data bit to distribute.
REQ-005 din_valid  input  1  din is offered this cycle.
REQ-006 din_ready  output  1  block accepts din this cycle.
REQ-007 mode  input  1  0 = addressed (lane chosen by s), 1 = auto (internal pointer).
REQ-008 s  input  3  target lane in addressed mode; ignored in auto mode.
REQ-009 result  output  8  parallel output word, registered.
REQ-010 out_valid  output  1  result holds a complete word.
REQ-011 out_ready  input  1  consumer takes result when out_valid is high.
REQ-012 ptr  output  3  current auto-mode fill lane.
REQ-013 overflow  output  1  sticky error flag.

Function
REQ-014 Transfer: bit accepted only on a cycle with din_valid && din_ready.
REQ-015 Word taken on a cycle with out_valid && out_ready.
REQ-016 Addressed mode: accepted bit writes result[s] with 1-cycle latency; other bits hold; out_valid rises on the next cycle and stays high until taken.
REQ-017 Addressed mode: din_ready = 1 always; a write while out_valid && !out_ready updates result[s] in place, keeps out_valid high, sets overflow.
REQ-018 Auto mode FSM states: FILL and FULL.
REQ-019 FILL: accepted bit is written to shadow[lane]; lane = ptr if LSB_FIRST = 1, else 7 - ptr; ptr increments modulo 8.
REQ-020 FILL, 8th bit accepted (ptr = 7): on the next edge, result = shadow including this bit; out_valid = 1; ptr wraps to 0; state -> FULL.
REQ-021 FULL: next word fills shadow while result holds; din_ready = 1 except when ptr = 7 and the word will not be taken this cycle (!out_ready).
REQ-022 FULL: word taken and no new word completes -> out_valid = 0, state -> FILL.
REQ-023 FULL: word taken and 8th bit of the next word accepted in the same cycle -> result loads the new word, out_valid stays 1, state stays FULL (zero-bubble back-to-back words).
REQ-024 Auto mode: no bit is lost or duplicated; overflow is never set.
REQ-025 Mode change: when mode differs from its value on the previous cycle, ptr = 0, shadow = 0, state = FILL; result, out_valid and overflow hold; any bit offered that cycle is processed under the new mode.
REQ-026 Shadow register is internal; result changes only on the edges defined in REQ-016, REQ-017, REQ-020 and REQ-023.
REQ-027 Outputs are registered except din_ready, which is combinational from state, ptr, mode and out_ready.

Reset
REQ-028 On a rst edge: result = 8'h00, out_valid = 0, ptr = 0, shadow = 0, overflow = 0, state = FILL.
REQ-029 rst overrides all other inputs; a partly filled word is discarded.
REQ-030 din_ready = 1 in the cycle after reset.
REQ-031 overflow clears only on reset.

Verification
REQ-032 Auto, LSB_FIRST=1, out_ready=1, bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> result = 8'h4D, out_valid high for exactly 1 cycle, ptr back to 0.
REQ-033 Same stimulus with LSB_FIRST=0 -> result = 8'hB2.
REQ-034 Auto, out_ready=0, 16 bits offered back-to-back -> out_valid high after bit 8; din_ready low while ptr = 7; raising out_ready -> first word taken, then 2nd word presented next cycle; overflow = 0.
REQ-035 Addressed, s=5, din=1 then s=0, din=1, out_ready=0 -> result = 8'h21, out_valid = 1, overflow = 1.
REQ-036 Auto, 5 bits accepted, then rst for 1 cycle -> all outputs at reset values; next 8 bits form a clean word.
REQ-037 Auto, 3 bits accepted, mode toggled to 0 then back to 1 -> ptr = 0, and the following 8 bits fill lanes 0-7 in order.
